// File: rtl/nov_shiftrow_pkg.sv
// Shared definitions for the dynamic ShiftRows datapath (forward and inverse).
// State layout: [127:120]=r0c0, [119:112]=r1c0, ..., [7:0]=r3c3 (column-major).
package nov_shiftrow_pkg;

    localparam int BYTE_W   = 8;
    localparam int COL_W    = 32;
    localparam int STATE_W  = 128;
    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;

    typedef logic [STATE_W-1:0] state_t;

    // Bit offset of the least significant bit of byte (row, col).
    function automatic int byte_lsb(logic [1:0] row, logic [1:0] col);
        return STATE_W - BYTE_W - COL_W * int'(col) - BYTE_W * int'(row);
    endfunction

    // Rotate one row so that out[c] = in[(c + amt) mod 4]; other rows pass through.
    function automatic state_t rot_row(state_t s, logic [1:0] row, logic [1:0] amt);
        state_t     r;
        logic [1:0] src;
        r = s;
        for (int c = 0; c < NUM_COLS; c++) begin
            src = 2'(c) + amt;
            r[byte_lsb(row, 2'(c)) +: BYTE_W] = s[byte_lsb(row, src) +: BYTE_W];
        end
        return r;
    endfunction

    // {p, w1}: p = parity of the whole state, w1 = AND of the four row-1 byte parities.
    // Both are invariant under any row rotation, so either side can recompute them.
    function automatic logic [1:0] parity_bits(state_t s);
        logic p;
        logic w1;
        p  = ^s;
        w1 = 1'b1;
        for (int c = 0; c < NUM_COLS; c++) begin
            w1 = w1 & (^s[byte_lsb(2'd1, 2'(c)) +: BYTE_W]);
        end
        return {p, w1};
    endfunction

    // Forward dynamic shift as used by the encryption datapath.
    function automatic state_t fwd_shift(state_t s, logic [1:0] mode);
        state_t t;
        t = rot_row(s, 2'd1, 2'd3);
        if (mode[1]) begin
            t = rot_row(t, 2'd2, 2'd2);
        end else begin
            t = rot_row(t, 2'd3, 2'd1);
        end
        t = rot_row(t, 2'd0, mode[0] ? 2'd1 : 2'd2);
        return t;
    endfunction

endpackage

// File: rtl/nov_inv_shiftrow_core.sv
// Combinational inverse dynamic ShiftRows permutation (src, p, w1) -> dst.
module nov_inv_shiftrow_core
    import nov_shiftrow_pkg::*;
(
    input  logic [127:0] src,
    input  logic         p,
    input  logic         w1,
    output logic [127:0] dst
);

    // Undo row1 always, then row2 or row3 depending on p, then row0 depending on w1.
    always_comb begin
        state_t t;
        t = rot_row(src, 2'd1, 2'd1);
        if (p) begin
            t = rot_row(t, 2'd2, 2'd2);
        end else begin
            t = rot_row(t, 2'd3, 2'd3);
        end
        t = rot_row(t, 2'd0, w1 ? 2'd3 : 2'd2);
        dst = t;
    end

endmodule

// File: rtl/nov_inv_shiftrow_pipe.sv
// Two-stage elastic pipeline restoring the AES state from a dynamically shifted one.
// S1 captures the shifted state and its {p,w1} control bits; S2 holds the permuted result.
// Handshake: a transfer happens on a rising edge where valid && ready; ready of each stage
// is !valid_k | ready_(k+1) and never depends on the upstream valid.
// Optional macro INV_SR_CHECK_EN: re-applies the forward shift to the S2 result and raises a
// sticky chk_err on any disagreement with the S1 state; otherwise chk_err is tied low.
module nov_inv_shiftrow_pipe
    import nov_shiftrow_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [127:0]     in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [127:0]     out_data,
    output logic [1:0]       out_mode,
    output logic [CNT_W-1:0] blk_cnt,
    output logic             chk_err
);

    logic         s1_v;
    logic [127:0] s1_data;
    logic [1:0]   s1_mode;
    logic         s2_v;
    logic [127:0] s2_data;
    logic [1:0]   s2_mode;
    logic         s1_ready;
    logic         s2_ready;
    logic [127:0] core_out;

    assign s2_ready = !s2_v || out_ready;
    assign s1_ready = !s1_v || s2_ready;
    assign in_ready = s1_ready;

    assign out_valid = s2_v;
    assign out_data  = s2_data;
    assign out_mode  = s2_mode;

    nov_inv_shiftrow_core u_core (
        .src (s1_data),
        .p   (s1_mode[1]),
        .w1  (s1_mode[0]),
        .dst (core_out)
    );

    // Stage 1: capture the shifted state and derive its control bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_v    <= 1'b0;
            s1_data <= '0;
            s1_mode <= 2'b00;
        end else if (s1_ready) begin
            s1_v <= in_valid;
            if (in_valid) begin
                s1_data <= in_data;
                s1_mode <= parity_bits(in_data);
            end
        end
    end

    // Stage 2: capture the un-shifted state; holds while the consumer stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_v    <= 1'b0;
            s2_data <= '0;
            s2_mode <= 2'b00;
        end else if (s2_ready) begin
            s2_v <= s1_v;
            if (s1_v) begin
                s2_data <= core_out;
                s2_mode <= s1_mode;
            end
        end
    end

    // Count delivered blocks, wrapping naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blk_cnt <= '0;
        end else if (s2_v && out_ready) begin
            blk_cnt <= blk_cnt + CNT_W'(1);
        end
    end

`ifdef INV_SR_CHECK_EN
    logic mismatch;

    assign mismatch = (fwd_shift(core_out, s1_mode) != s1_data);

    // Sticky error when the restored state does not shift back to the captured input.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chk_err <= 1'b0;
        end else if (s1_v && s2_ready && mismatch) begin
            chk_err <= 1'b1;
        end
    end
`else
    assign chk_err = 1'b0;
`endif

endmodule
